// File: rtl/window_ram_pkg.sv
// window_ram shared types: FSM state, default geometry and pixel word type.
// Consumed by window_ram and window_addr_gen.
package window_ram_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 20;
   localparam int DEF_DEPTH  = 1048576;
   localparam int DEF_K      = 5;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DONE
   } state_t;

   typedef logic signed [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/window_addr_gen.sv
// One window column: element address base + row*stride + COL and its
// in-range flag, evaluated wide enough that nothing wraps.
module window_addr_gen
   import window_ram_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int K      = DEF_K,
   parameter int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int RW     = (K > 1) ? $clog2(K) : 1,
   parameter int COL    = 0
) (
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] stride,
   input  logic [RW-1:0]     row,
   output logic [IW-1:0]     idx,
   output logic              in_range
);

   localparam int EW = ADDR_W + RW + ADDR_W;

   logic [EW-1:0] elem;

   assign elem     = EW'(base) + EW'(row) * EW'(stride) + EW'(COL);
   assign in_range = elem < EW'(DEPTH);
   assign idx      = elem[IW-1:0];

endmodule

// File: rtl/window_ram.sv
// Single-port scratch RAM serving a KxK window (one row per cycle) or a word write.
// INIT_FILE parameter exists only when WINDOW_RAM_PRELOAD_EN is defined.
module window_ram
   import window_ram_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int K      = DEF_K
`ifdef WINDOW_RAM_PRELOAD_EN
   ,
   parameter string INIT_FILE = "LoadMem.mem"
`endif
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              write,
   input  logic [ADDR_W-1:0]                 address,
   input  logic [ADDR_W-1:0]                 offset,
   input  logic [DATA_W-1:0]                 input_data,
   output logic                              busy,
   output logic                              done,
   output logic                              oob,
   output logic [0:K-1][0:K-1][DATA_W-1:0]   win_data
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int RW = (K > 1) ? $clog2(K) : 1;
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

   state_t                          state_q, state_d;
   logic [ADDR_W-1:0]               base_q, base_d;
   logic [ADDR_W-1:0]               stride_q, stride_d;
   logic [RW-1:0]                   row_q, row_d;
   logic                            oob_q, oob_d;
   logic [0:K-1][0:K-1][DATA_W-1:0] win_q, win_d;

   logic [DATA_W-1:0]               mem [DEPTH];
   logic [IW-1:0]                   idx [K];
   logic [K-1:0]                    col_ok;
   logic [0:K-1][DATA_W-1:0]        rd_data;
   logic                            accept;
   logic                            wr_ok;
   logic                            wr_en;

   generate
      for (genvar c = 0; c < K; c++) begin : g_col
         window_addr_gen #(
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH),
            .K      (K),
            .IW     (IW),
            .RW     (RW),
            .COL    (c)
         ) u_gen (
            .base     (base_q),
            .stride   (stride_q),
            .row      (row_q),
            .idx      (idx[c]),
            .in_range (col_ok[c])
         );
         assign rd_data[c] = col_ok[c] ? mem[idx[c]] : '0;
      end
   endgenerate

   assign accept = (state_q == IDLE) && start;
   assign wr_ok  = {1'b0, address} < DEPTH_X;
   assign wr_en  = accept && write && wr_ok && !rst;

   always_ff @(posedge clk) begin
      if (wr_en) mem[address[IW-1:0]] <= input_data;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = write ? DONE : READ;
         READ:    if (row_q == RW'(K-1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy     = state_q != IDLE;
      done     = state_q == DONE;
      oob      = oob_q;
      win_data = win_q;
   end

   // oob is sticky across the whole window and cleared only by a new request
   always_comb begin
      base_d   = base_q;
      stride_d = stride_q;
      row_d    = row_q;
      oob_d    = oob_q;
      win_d    = win_q;
      if (accept) begin
         if (write) begin
            oob_d = !wr_ok;
         end else begin
            base_d   = address;
            stride_d = offset;
            row_d    = '0;
            oob_d    = 1'b0;
         end
      end else if (state_q == READ) begin
         win_d[row_q] = rd_data;
         row_d        = row_q + RW'(1);
         oob_d        = oob_q | ~&col_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base_q   <= '0;
         stride_q <= '0;
         row_q    <= '0;
         oob_q    <= 1'b0;
         win_q    <= '0;
      end else begin
         base_q   <= base_d;
         stride_q <= stride_d;
         row_q    <= row_d;
         oob_q    <= oob_d;
         win_q    <= win_d;
      end
   end

endmodule
